// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch port, the load/store port, the memory port and the stall
//          line shared by mem_port_arbiter and its surroundings.
// Ports:   slave  - arbiter view (requests and mem_rdata in; responses, memory strobes, stall out)
//          master - requester/memory view (mirror of slave)
interface mem_port_arbiter_if;

   // fetch port
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;

   // load/store port
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_valid;

   // single-ported memory
   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   // pipeline hold
   logic        stall;

   modport slave (
      input  if_req, if_addr,
      input  d_req, d_we, d_be, d_addr, d_wdata,
      input  mem_rdata,
      output if_rdata, if_valid,
      output d_rdata, d_valid,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output stall
   );

   modport master (
      output if_req, if_addr,
      output d_req, d_we, d_be, d_addr, d_wdata,
      output mem_rdata,
      input  if_rdata, if_valid,
      input  d_rdata, d_valid,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  stall
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates fetch vs load/store onto one single-ported memory; data wins unless the starve guard fires.
// Latency: request sampled in IDLE -> mem_en next cycle -> x_valid LATENCY+1 cycles later; one access per LATENCY+3 cycles.
// Backpressure: requests are level-held until their x_valid pulse; stall is high while any requester is waiting.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset (clears state, discards any in-flight access)
//   bus  - mem_port_arbiter_if.slave: if_* fetch port, d_* load/store port, mem_* memory port, stall
// Parameters:
//   LATENCY      - memory read latency, 1..8
//   STARVE_LIMIT - consecutive data grants tolerated while fetch waits, 1..15
// Build option:
//   ARB_STARVE_GUARD_EN - when defined, a fetch grant is forced after STARVE_LIMIT
//                         consecutive data grants made while if_req was high.
module mem_port_arbiter #(
   parameter int unsigned LATENCY      = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);

   // Reject out-of-range configurations at elaboration.
   if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
      $error("mem_port_arbiter: LATENCY must be in 1..8");
   end
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
      $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
   end

   localparam logic [3:0] LAT4 = 4'(LATENCY);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t      state_q,    state_d;
   logic        grant_q,    grant_d;     // 1 = data port owns the access, 0 = fetch
   logic        we_q,       we_d;
   logic [3:0]  be_q,       be_d;
   logic [31:0] addr_q,     addr_d;
   logic [31:0] wdata_q,    wdata_d;
   logic [3:0]  cnt_q,      cnt_d;       // remaining read-latency cycles in WAIT
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] d_rdata_q,  d_rdata_d;

   logic        take_data;               // arbitration result for this IDLE cycle

`ifdef ARB_STARVE_GUARD_EN
   localparam logic [3:0] STARVE4 = 4'(STARVE_LIMIT);

   logic [3:0]  starve_q,   starve_d;
   logic        force_fetch;
`endif

   //--------------------------------------------------------------------------
   // Next-state and datapath
   //--------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      we_d       = we_q;
      be_d       = be_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      take_data  = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_d    = starve_q;
      // Once fetch has watched STARVE_LIMIT data grants go by, it wins the next one.
      force_fetch = bus.if_req && (starve_q == STARVE4);
      take_data   = bus.d_req && !force_fetch;
`else
      take_data   = bus.d_req;
`endif

      case (state_q)
         IDLE: begin
            if (bus.d_req || bus.if_req) begin
               grant_d = take_data;
               state_d = ISSUE;
               if (take_data) begin
                  we_d    = bus.d_we;
                  be_d    = bus.d_be;
                  addr_d  = bus.d_addr;
                  wdata_d = bus.d_wdata;
               end else begin
                  // Fetch is always a full-word read; write data is left as it was.
                  we_d    = 1'b0;
                  be_d    = 4'b1111;
                  addr_d  = bus.if_addr;
               end
`ifdef ARB_STARVE_GUARD_EN
               // Only data grants that overtook a waiting fetch count toward starvation.
               if (take_data && bus.if_req) begin
                  starve_d = starve_q + 4'd1;
               end else begin
                  starve_d = '0;
               end
`endif
            end
         end

         ISSUE: begin
            cnt_d   = LAT4;
            state_d = WAIT;
         end

         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               // mem_rdata is valid in this cycle; capture it into the owner's register.
               // Stores leave d_rdata alone.
               if (grant_q) begin
                  if (!we_q) begin
                     d_rdata_d = bus.mem_rdata;
                  end
               end else begin
                  if_rdata_d = bus.mem_rdata;
               end
               state_d = RESP;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   //--------------------------------------------------------------------------
   // State registers
   //--------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         grant_q    <= 1'b0;
         we_q       <= 1'b0;
         be_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         we_q       <= we_d;
         be_q       <= be_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

`ifdef ARB_STARVE_GUARD_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`endif

   //--------------------------------------------------------------------------
   // Outputs
   //--------------------------------------------------------------------------
   // Address/byte-enable/write-data hold the last issued values between accesses;
   // only the strobes are qualified by ISSUE.
   assign bus.mem_en    = (state_q == ISSUE);
   assign bus.mem_we    = (state_q == ISSUE) && we_q;
   assign bus.mem_be    = be_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

   assign bus.if_valid  = (state_q == RESP) && !grant_q;
   assign bus.d_valid   = (state_q == RESP) &&  grant_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;

   // Combinational so the PC is held in the same cycle a request is raised.
   assign bus.stall = (bus.if_req && !bus.if_valid) || (bus.d_req && !bus.d_valid);

endmodule
